// File: rtl/imem_prog.sv
// Synchronous-read instruction memory with an in-system programming port.
// After reset it clears itself to NOP_WORD, then serves fetches or accepts a streamed program.
module imem_prog #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  prog_start,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  prog_done,
  output logic [ADDR_WIDTH:0]   prog_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  load_exit;
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] instr_p1;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_wdata = NOP_WORD;
    load_exit = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        rd_en = fetch_en;
        if (prog_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (prog_valid) begin
          mem_we    = 1'b1;
          mem_wdata = prog_data;
          ptr_d     = ptr_q + 1'b1;
          // A full memory ends the load even without prog_last.
          if (prog_last || ptr_q == PTR_LAST) begin
            load_exit = 1'b1;
            state_d   = S_RUN;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control and fetch pipeline: request at edge N, data registered at edge N
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      ptr_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= load_exit;
      vld_p1  <= rd_en;
      if (load_exit) count_q <= {1'b0, ptr_q} + 1'b1;
      if (rd_en) instr_p1 <= mem[fetch_addr];
    end
  end

  // Storage write port; suppressed while reset is held
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= mem_wdata;
  end

  assign fetch_ready = (state_q == S_RUN);
  assign prog_ready  = (state_q == S_LOAD);
  assign prog_done   = done_q;
  assign prog_count  = count_q;
  assign instr       = instr_p1;
  assign instr_valid = vld_p1;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog with ADDR_WIDTH=4, DATA_WIDTH=16.
module tb_imem_prog;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          prog_start;
  logic          prog_valid;
  logic [DW-1:0] prog_data;
  logic          prog_last;
  logic          prog_ready;
  logic          prog_done;
  logic [AW:0]   prog_count;

  int n_chk  = 0;
  int n_pass = 0;

  imem_prog #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .prog_done(prog_done),
    .prog_count(prog_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_en   = 1'b0;
    fetch_addr = '0;
    prog_start = 1'b0;
    prog_valid = 1'b0;
    prog_data  = '0;
    prog_last  = 1'b0;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    d = instr;
    v = instr_valid;
    fetch_en = 1'b0;
  endtask

  task automatic begin_load();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) tick();
    n_chk++; if (instr !== 16'h0000) $display("FAIL rst_instr: got %h want 0000", instr); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (fetch_ready !== 1'b0) $display("FAIL rst_fetch_ready: got %b want 0", fetch_ready); else n_pass++;
    n_chk++; if (prog_ready !== 1'b0) $display("FAIL rst_prog_ready: got %b want 0", prog_ready); else n_pass++;
    n_chk++; if (prog_done !== 1'b0) $display("FAIL rst_prog_done: got %b want 0", prog_done); else n_pass++;
    n_chk++; if (prog_count !== 5'd0) $display("FAIL rst_prog_count: got %0d want 0", prog_count); else n_pass++;
    // Fetch requested during CLEAR must be ignored.
    fetch_en   = 1'b1;
    fetch_addr = 4'd3;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_chk++; if (fetch_ready !== (i == 16)) $display("FAIL clear_fetch_ready[%0d]: got %b want %b", i, fetch_ready, (i == 16)); else n_pass++;
      n_chk++; if (instr_valid !== 1'b0) $display("FAIL clear_no_valid[%0d]: got %b want 0", i, instr_valid); else n_pass++;
    end
    fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_clear_contents();
    logic [DW-1:0] d;
    logic          v;
    for (int a = 0; a < 16; a++) begin
      do_fetch(AW'(a), d, v);
      n_chk++; if (d !== 16'h0000) $display("FAIL clear_word[%0d]: got %h want 0000", a, d); else n_pass++;
      n_chk++; if (v !== 1'b1) $display("FAIL clear_word_valid[%0d]: got %b want 1", a, v); else n_pass++;
    end
    tick();
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL valid_pulse: got %b want 0", instr_valid); else n_pass++;
  endtask

  task automatic test_load_last();
    logic [DW-1:0] beats [3] = '{16'h2000, 16'h2101, 16'h0996};
    logic [DW-1:0] want  [4] = '{16'h2000, 16'h2101, 16'h0996, 16'h0000};
    logic [DW-1:0] d;
    logic          v;
    begin_load();
    n_chk++; if (prog_ready !== 1'b1) $display("FAIL load_prog_ready: got %b want 1", prog_ready); else n_pass++;
    n_chk++; if (fetch_ready !== 1'b0) $display("FAIL load_fetch_ready: got %b want 0", fetch_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1;
      prog_data  = beats[i];
      prog_last  = (i == 2);
      tick();
    end
    idle();
    n_chk++; if (prog_done !== 1'b1) $display("FAIL last_done: got %b want 1", prog_done); else n_pass++;
    n_chk++; if (fetch_ready !== 1'b1) $display("FAIL last_fetch_ready: got %b want 1", fetch_ready); else n_pass++;
    n_chk++; if (prog_ready !== 1'b0) $display("FAIL last_prog_ready: got %b want 0", prog_ready); else n_pass++;
    n_chk++; if (prog_count !== 5'd3) $display("FAIL last_count: got %0d want 3", prog_count); else n_pass++;
    tick();
    n_chk++; if (prog_done !== 1'b0) $display("FAIL last_done_pulse: got %b want 0", prog_done); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      do_fetch(AW'(a), d, v);
      n_chk++; if (d !== want[a] || v !== 1'b1) $display("FAIL last_word[%0d]: got %h/%b want %h/1", a, d, v, want[a]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want [4] = '{16'h0000, 16'h0996, 16'h2101, 16'h2000};
    fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = AW'(3 - i);
      tick();
      n_chk++; if (instr !== want[i] || instr_valid !== 1'b1) $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, instr, instr_valid, want[i]); else n_pass++;
    end
    fetch_en   = 1'b0;
    fetch_addr = 4'd1;
    tick();
    n_chk++; if (instr !== 16'h2000 || instr_valid !== 1'b0) $display("FAIL b2b_hold: got %h/%b want 2000/0", instr, instr_valid); else n_pass++;
  endtask

  task automatic test_throttled();
    logic          vpat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic          lpat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] want [4] = '{16'hA000, 16'hA003, 16'hA004, 16'h0000};
    logic [DW-1:0] d;
    logic          v;
    begin_load();
    for (int i = 0; i < 5; i++) begin
      prog_valid = vpat[i];
      prog_last  = lpat[i];
      prog_data  = 16'hA000 + 16'(i);
      tick();
    end
    idle();
    n_chk++; if (prog_done !== 1'b1 || prog_count !== 5'd3) $display("FAIL thr_done_count: got %b/%0d want 1/3", prog_done, prog_count); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      do_fetch(AW'(a), d, v);
      n_chk++; if (d !== want[a]) $display("FAIL thr_word[%0d]: got %h want %h", a, d, want[a]); else n_pass++;
    end
  endtask

  task automatic test_full();
    int            accepted = 0;
    int            dones    = 0;
    int            done_at  = 0;
    logic          rdy_b;
    logic          rdy_after16 = 1'b1;
    logic [DW-1:0] d;
    logic          v;
    begin_load();
    for (int i = 1; i <= 20; i++) begin
      prog_valid = 1'b1;
      prog_last  = 1'b0;
      prog_data  = 16'h3000 + 16'(i);
      rdy_b = prog_ready;
      tick();
      if (rdy_b) accepted++;
      if (prog_done) begin
        dones++;
        done_at = i;
      end
      if (i == 16) rdy_after16 = prog_ready;
    end
    idle();
    n_chk++; if (accepted !== 16) $display("FAIL full_accepted: got %0d want 16", accepted); else n_pass++;
    n_chk++; if (dones !== 1 || done_at !== 16) $display("FAIL full_done: got %0d pulses at %0d want 1 at 16", dones, done_at); else n_pass++;
    n_chk++; if (rdy_after16 !== 1'b0) $display("FAIL full_ready_drop: got %b want 0", rdy_after16); else n_pass++;
    n_chk++; if (prog_count !== 5'd16) $display("FAIL full_count: got %0d want 16", prog_count); else n_pass++;
    do_fetch(4'd15, d, v);
    n_chk++; if (d !== 16'h3010) $display("FAIL full_word15: got %h want 3010", d); else n_pass++;
    do_fetch(4'd0, d, v);
    n_chk++; if (d !== 16'h3001) $display("FAIL full_word0: got %h want 3001", d); else n_pass++;
  endtask

  task automatic test_ignored();
    logic [DW-1:0] beats [3] = '{16'hB000, 16'hB001, 16'hB002};
    logic [DW-1:0] d;
    logic          v;
    begin_load();
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1;
      prog_data  = beats[i];
      prog_last  = (i == 2);
      fetch_en   = 1'b1;
      fetch_addr = 4'd15;
      prog_start = (i == 1);
      tick();
      n_chk++; if (instr !== 16'h3001 || instr_valid !== 1'b0) $display("FAIL ign_fetch[%0d]: got %h/%b want 3001/0", i, instr, instr_valid); else n_pass++;
    end
    idle();
    n_chk++; if (prog_count !== 5'd3) $display("FAIL ign_count: got %0d want 3", prog_count); else n_pass++;
    for (int a = 0; a < 3; a++) begin
      do_fetch(AW'(a), d, v);
      n_chk++; if (d !== beats[a]) $display("FAIL ign_word[%0d]: got %h want %h", a, d, beats[a]); else n_pass++;
    end
  endtask

  task automatic test_reset_midload();
    logic [DW-1:0] d;
    logic          v;
    begin_load();
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1'b1;
      prog_data  = 16'h5000 + 16'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    // Address 15 holds a stale nonzero word until the clear reaches it.
    fetch_en   = 1'b1;
    fetch_addr = 4'd15;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_chk++; if (fetch_ready !== (i == 16)) $display("FAIL reclr_fetch_ready[%0d]: got %b want %b", i, fetch_ready, (i == 16)); else n_pass++;
      n_chk++; if (instr !== 16'h0000 || instr_valid !== 1'b0) $display("FAIL reclr_ignored[%0d]: got %h/%b want 0000/0", i, instr, instr_valid); else n_pass++;
    end
    fetch_en = 1'b0;
    n_chk++; if (prog_count !== 5'd0) $display("FAIL reclr_count: got %0d want 0", prog_count); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      do_fetch(AW'(a), d, v);
      n_chk++; if (d !== 16'h0000 || v !== 1'b1) $display("FAIL reclr_word[%0d]: got %h/%b want 0000/1", a, d, v); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_load_last();
    test_back_to_back();
    test_throttled();
    test_full();
    test_ignored();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
